// File: rtl/hazard_pkg.sv
// Shared types and limits for the pipeline hazard controller.
package hazard_pkg;

    localparam int MEM_LAT_MAX = 15;
    localparam int LAT_CNT_W   = 4;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        RELEASE
    } mem_state_t;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// E-stage operand bypass select for one source register; M result wins over W.
module forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] ra_e,
    input  logic [REG_W-1:0] wa_m,
    input  logic [REG_W-1:0] wa_w,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    output fwd_sel_t         fwd_sel
);

    always_comb begin
        if (regwrite_m && (wa_m == ra_e)) begin
            fwd_sel = FWD_M;
        end else if (regwrite_w && (wa_w == ra_e)) begin
            fwd_sel = FWD_W;
        end else begin
            fwd_sel = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding, load-use, branch flush,
// multicycle data-memory wait sequencing and saturating stall/flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W   = 4,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] ra1_d,
    input  logic [REG_W-1:0] ra2_d,
    input  logic [REG_W-1:0] ra1_e,
    input  logic [REG_W-1:0] ra2_e,
    input  logic [REG_W-1:0] wa_e,
    input  logic [REG_W-1:0] wa_m,
    input  logic [REG_W-1:0] wa_w,
    input  logic             memtoreg_e,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    input  logic             mem_req_m,
    input  logic             pcsrc_e,
    output logic [1:0]       forward_ae,
    output logic [1:0]       forward_be,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam bit MULTI = (MEM_LAT > 1);
    localparam bit LONG  = (MEM_LAT > 2);
    localparam logic [LAT_CNT_W-1:0] LOAD_VAL =
        LAT_CNT_W'((MEM_LAT > 2) ? (MEM_LAT - 2) : 0);

    fwd_sel_t             fwd_a;
    fwd_sel_t             fwd_b;
    mem_state_t           state;
    mem_state_t           state_nxt;
    logic [LAT_CNT_W-1:0] wcnt;
    logic [LAT_CNT_W-1:0] wcnt_nxt;
    logic                 mstall;
    logic                 lwstall;
    logic                 branch;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    forward_unit #(.REG_W(REG_W)) u_fwd_a (
        .ra_e       (ra1_e),
        .wa_m       (wa_m),
        .wa_w       (wa_w),
        .regwrite_m (regwrite_m),
        .regwrite_w (regwrite_w),
        .fwd_sel    (fwd_a)
    );

    forward_unit #(.REG_W(REG_W)) u_fwd_b (
        .ra_e       (ra2_e),
        .wa_m       (wa_m),
        .wa_w       (wa_w),
        .regwrite_m (regwrite_m),
        .regwrite_w (regwrite_w),
        .fwd_sel    (fwd_b)
    );

    assign forward_ae = fwd_a;
    assign forward_be = fwd_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // RELEASE ignores mem_req_m so the still-held access in M cannot re-trigger.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            RUN: begin
                if (mem_req_m && MULTI) begin
                    wcnt_nxt  = LOAD_VAL;
                    state_nxt = LONG ? WAIT : RELEASE;
                end
            end
            WAIT: begin
                wcnt_nxt = wcnt - 1'b1;
                if (wcnt == LAT_CNT_W'(1)) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        mstall  = ((state == RUN) && mem_req_m && MULTI) || (state == WAIT);
        lwstall = memtoreg_e && ((wa_e == ra1_d) || (wa_e == ra2_d)) && !mstall;
        branch  = pcsrc_e && !mstall;
        stall_f = !reset && (mstall || (lwstall && !pcsrc_e));
        stall_d = !reset && (mstall || (lwstall && !pcsrc_e));
        stall_e = !reset && mstall;
        stall_m = !reset && mstall;
        flush_d = !reset && branch;
        flush_e = !reset && (branch || lwstall);
        flush_w = !reset && mstall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (flush_e) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: three instances (MEM_LAT 4/5/1) share one stimulus stream.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] ra1_d, ra2_d, ra1_e, ra2_e, wa_e, wa_m, wa_w;
    logic       memtoreg_e, regwrite_m, regwrite_w, mem_req_m, pcsrc_e;

    logic [1:0]  fae4, fbe4, fae5, fbe5, fae1, fbe1;
    logic        sf4, sd4, se4, sm4, fd4, fe4, fw4;
    logic        sf5, sd5, se5, sm5, fd5, fe5, fw5;
    logic        sf1, sd1, se1, sm1, fd1, fe1, fw1;
    logic [15:0] sc4, fc4, sc1, fc1;
    logic [3:0]  sc5, fc5;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(4), .MEM_LAT(4), .CNT_W(16)) u_l4 (
        .clk(clk), .reset(reset), .ra1_d(ra1_d), .ra2_d(ra2_d), .ra1_e(ra1_e), .ra2_e(ra2_e),
        .wa_e(wa_e), .wa_m(wa_m), .wa_w(wa_w), .memtoreg_e(memtoreg_e), .regwrite_m(regwrite_m),
        .regwrite_w(regwrite_w), .mem_req_m(mem_req_m), .pcsrc_e(pcsrc_e),
        .forward_ae(fae4), .forward_be(fbe4), .stall_f(sf4), .stall_d(sd4), .stall_e(se4),
        .stall_m(sm4), .flush_d(fd4), .flush_e(fe4), .flush_w(fw4),
        .stall_cnt(sc4), .flush_cnt(fc4)
    );

    hazard_ctrl #(.REG_W(4), .MEM_LAT(5), .CNT_W(4)) u_l5 (
        .clk(clk), .reset(reset), .ra1_d(ra1_d), .ra2_d(ra2_d), .ra1_e(ra1_e), .ra2_e(ra2_e),
        .wa_e(wa_e), .wa_m(wa_m), .wa_w(wa_w), .memtoreg_e(memtoreg_e), .regwrite_m(regwrite_m),
        .regwrite_w(regwrite_w), .mem_req_m(mem_req_m), .pcsrc_e(pcsrc_e),
        .forward_ae(fae5), .forward_be(fbe5), .stall_f(sf5), .stall_d(sd5), .stall_e(se5),
        .stall_m(sm5), .flush_d(fd5), .flush_e(fe5), .flush_w(fw5),
        .stall_cnt(sc5), .flush_cnt(fc5)
    );

    hazard_ctrl #(.REG_W(4), .MEM_LAT(1), .CNT_W(16)) u_l1 (
        .clk(clk), .reset(reset), .ra1_d(ra1_d), .ra2_d(ra2_d), .ra1_e(ra1_e), .ra2_e(ra2_e),
        .wa_e(wa_e), .wa_m(wa_m), .wa_w(wa_w), .memtoreg_e(memtoreg_e), .regwrite_m(regwrite_m),
        .regwrite_w(regwrite_w), .mem_req_m(mem_req_m), .pcsrc_e(pcsrc_e),
        .forward_ae(fae1), .forward_be(fbe1), .stall_f(sf1), .stall_d(sd1), .stall_e(se1),
        .stall_m(sm1), .flush_d(fd1), .flush_e(fe1), .flush_w(fw1),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Control vector layout: {forward_ae, forward_be, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w}
    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return 32'({fae4, fbe4, sf4, sd4, se4, sm4, fd4, fe4, fw4});
            1:       return 32'(sc4);
            2:       return 32'(fc4);
            3:       return 32'({fae5, fbe5, sf5, sd5, se5, sm5, fd5, fe5, fw5});
            4:       return 32'(sc5);
            5:       return 32'(fc5);
            6:       return 32'({fae1, fbe1, sf1, sd1, se1, sm1, fd1, fe1, fw1});
            default: return 32'hdead_beef;
        endcase
    endfunction

    function automatic logic [31:0] fv(input logic [1:0] fa, input logic [1:0] fb);
        return 32'({fa, fb, 7'b0});
    endfunction

    localparam logic [31:0] MEM_V = 32'b000_1111_001;
    localparam logic [31:0] LU_V  = 32'b000_1100_010;
    localparam logic [31:0] BR_V  = 32'b000_0000_110;

    // Single access starting at cycle base of period L: L-1 stall cycles then one release cycle.
    function automatic bit mem_stall_exp(input int k, input int lat, input int req_len);
        return ((k % lat) != (lat - 1)) && ((k - (k % lat)) < req_len);
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic push_all(input string tag, input logic [31:0] exp);
        push(tag, 0, exp);
        push(tag, 3, exp);
        push(tag, 6, exp);
    endtask

    task automatic idle();
        ra1_d = '0; ra2_d = '0; ra1_e = '0; ra2_e = '0;
        wa_e = '0; wa_m = '0; wa_w = '0;
        memtoreg_e = 1'b0; regwrite_m = 1'b0; regwrite_w = 1'b0;
        mem_req_m = 1'b0; pcsrc_e = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            check_eq(e.tag, observe(e.sel), e.exp);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        idle();
        tick();
        push_all("rst_idle", 32'd0);
        push("rst_sc4", 1, 32'd0);
        push("rst_fc5", 5, 32'd0);
        tick();
        memtoreg_e = 1'b1; wa_e = 4'd5; ra2_d = 4'd5; pcsrc_e = 1'b1; mem_req_m = 1'b1;
        push_all("rst_mask", 32'd0);
        tick();
        reset = 1'b0;
        idle();
        push_all("idle", 32'd0);

        tick();
        ra1_e = 4'd3; wa_m = 4'd3; regwrite_m = 1'b1; wa_w = 4'd3; regwrite_w = 1'b1;
        push_all("fwd_m_pri", fv(2'b10, 2'b00));
        tick();
        regwrite_m = 1'b0;
        push_all("fwd_w", fv(2'b01, 2'b00));
        tick();
        regwrite_m = 1'b1; wa_m = 4'd7; ra2_e = 4'd7;
        push_all("fwd_mix", fv(2'b01, 2'b10));
        tick();
        regwrite_w = 1'b0; wa_m = 4'd3; ra2_e = 4'd9;
        push_all("fwd_rf", fv(2'b10, 2'b00));

        tick();
        idle();
        memtoreg_e = 1'b1; wa_e = 4'd5; ra2_d = 4'd5;
        push_all("lu", LU_V);
        tick();
        idle();
        push_all("lu_end", 32'd0);
        push("lu_sc4", 1, 32'd1);
        push("lu_fc4", 2, 32'd1);
        push("lu_sc5", 4, 32'd1);
        tick();
        wa_e = 4'd6; ra1_d = 4'd6;
        push_all("no_load", 32'd0);

        tick();
        idle();
        pcsrc_e = 1'b1;
        push_all("br", BR_V);
        tick();
        memtoreg_e = 1'b1; wa_e = 4'd2; ra1_d = 4'd2;
        push_all("br_lu", BR_V);
        tick();
        idle();
        push("br_sc4", 1, 32'd1);
        push("br_fc4", 2, 32'd3);

        for (int k = 0; k < 10; k++) begin
            tick();
            idle();
            mem_req_m = (k < 8);
            push($sformatf("mem4_c%0d", k), 0, mem_stall_exp(k, 4, 8) ? MEM_V : 32'd0);
            push($sformatf("mem5_c%0d", k), 3, mem_stall_exp(k, 5, 8) ? MEM_V : 32'd0);
            push($sformatf("mem1_c%0d", k), 6, mem_stall_exp(k, 1, 8) ? MEM_V : 32'd0);
        end
        tick();
        push("mem_sc4", 1, 32'd7);
        push("mem_sc5", 4, 32'd9);
        push("mem_fc4", 2, 32'd3);

        tick();
        reset = 1'b1;
        push("rst2_sc4", 1, 32'd0);
        push("rst2_fc4", 2, 32'd0);
        tick();
        reset = 1'b0;

        for (int k = 0; k < 6; k++) begin
            tick();
            idle();
            pcsrc_e = 1'b1; memtoreg_e = 1'b1; wa_e = 4'd2; ra1_d = 4'd2;
            mem_req_m = (k == 0);
            push($sformatf("mask4_c%0d", k), 0, (k < 3) ? MEM_V : BR_V);
            push($sformatf("mask5_c%0d", k), 3, (k < 4) ? MEM_V : BR_V);
            push($sformatf("mask1_c%0d", k), 6, BR_V);
        end

        tick();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        tick();
        mem_req_m = 1'b1;
        push("rw_run", 3, MEM_V);
        tick();
        push("rw_wait1", 3, MEM_V);
        tick();
        reset = 1'b1;
        push_all("rw_rst", 32'd0);
        push("rw_rst_sc5", 4, 32'd0);
        tick();
        reset = 1'b0;
        mem_req_m = 1'b0;
        push_all("rw_after", 32'd0);
        push("rw_after_sc5", 4, 32'd0);
        tick();
        push_all("rw_after2", 32'd0);
        push("rw_after2_sc5", 4, 32'd0);

        for (int k = 0; k < 20; k++) begin
            tick();
            idle();
            memtoreg_e = 1'b1; wa_e = 4'd5; ra2_d = 4'd5;
            push($sformatf("sat_v%0d", k), 3, LU_V);
            push($sformatf("sat_sc%0d", k), 4, (k < 15) ? 32'(k) : 32'd15);
        end
        tick();
        idle();
        push("sat_end_sc5", 4, 32'd15);
        push("sat_end_fc5", 5, 32'd15);
        push("sat_end_sc4", 1, 32'd20);
        tick();
        push("sat_hold_sc5", 4, 32'd15);

        tick();
        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
